// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues one memory request at a time, buffers responses
// (or misalignment faults) in a small FIFO, and discards responses orphaned by a flush.
module inst_fetch #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_fault,
  output logic [1:0]  dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // Debug encoding: IDLE=0, WAIT=1, DROP=2.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [31:0]    lat_pc_q, lat_pc_d;

  logic [31:0]    pc_mem_q    [FIFO_DEPTH];
  logic [31:0]    inst_mem_q  [FIFO_DEPTH];
  logic           fault_mem_q [FIFO_DEPTH];

  logic           space;
  logic           aligned;
  logic           grant;
  logic           push;
  logic           pop;
  logic [31:0]    push_pc;
  logic [31:0]    push_inst;
  logic           push_fault;

  always_comb begin
    space     = (count_q < DEPTH_C);
    aligned   = (pc_in[1:0] == 2'b00);
    imem_req  = (state_q == IDLE) & pc_valid & space & ~flush & aligned;
    grant     = imem_req & imem_gnt;
    pc_ready  = (state_q == IDLE) & ~flush & space & pc_valid & (grant | ~aligned);
    imem_addr = pc_in;
    out_valid = (count_q != '0);
    pop       = out_valid & out_ready;

    push       = 1'b0;
    push_pc    = pc_in;
    push_inst  = 32'h0;
    push_fault = 1'b0;
    state_d    = state_q;
    lat_pc_d   = lat_pc_q;

    case (state_q)
      IDLE: begin
        if (grant) begin
          lat_pc_d = pc_in;
          state_d  = WAIT;
        end else if (pc_ready) begin
          // Misaligned fetch: report the fault without touching memory.
          push       = 1'b1;
          push_fault = 1'b1;
        end
      end
      WAIT: begin
        if (flush) begin
          state_d = imem_rvalid ? IDLE : DROP;
        end else if (imem_rvalid) begin
          push      = 1'b1;
          push_pc   = lat_pc_q;
          push_inst = imem_rdata;
          state_d   = IDLE;
        end
      end
      DROP: begin
        if (imem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
      count_d  = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      lat_pc_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      lat_pc_q <= lat_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= push_pc;
      inst_mem_q[wr_ptr_q]  <= push_inst;
      fault_mem_q[wr_ptr_q] <= push_fault;
    end
  end

  assign out_pc    = pc_mem_q[rd_ptr_q];
  assign out_inst  = inst_mem_q[rd_ptr_q];
  assign out_fault = fault_mem_q[rd_ptr_q];
  assign dbg_state = state_q;

endmodule
